distribute_multimode: RTL and testbench

Parametrised successor of the single-mode `distribute` stage in RTLinf. It moves `GROUP_SIZE`-wide activation/weight words from `NUM_INPUTS` read streams to `NUM_LANES` compute lanes over `num_iters` × `num_reads_per_iter` transfers. It supports direct, broadcast and round-robin scatter modes with per-lane valid/avail handshakes and a registered output stage. It sits between the BRAM/READ modules and the lane datapaths.

---
 rtl/distribute_pkg.sv | 27 ++
 rtl/distribute_lane_reg.sv | 35 +++
 rtl/distribute_multimode.sv | 197 +++++++++++++++++++
 tb/tb_distribute_multimode.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/distribute_pkg.sv
// Shared types and helpers for the distribute_multimode stage.
package distribute_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BCAST  = 2'd1,
    MODE_RR     = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/distribute_lane_reg.sv
// One-stage valid/avail output register feeding a single compute lane.
module distribute_lane_reg #(
  parameter int GW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [GW-1:0] i_data,
  input  logic          i_avail,
  output logic          o_space,
  output logic [GW-1:0] o_data,
  output logic          o_valid
);

  logic          r_valid;
  logic [GW-1:0] r_data;

  // Space also when the held word leaves this cycle, so a lane can stream one word per cycle.
  assign o_space = !r_valid || i_avail;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_avail) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/distribute_multimode.sv
// Moves words from NUM_INPUTS streams to NUM_LANES lanes in direct/broadcast/round-robin mode.
// Round-robin scatter is present only when DISTRIBUTE_RR_MODE_EN is defined; otherwise mode 2 acts as direct.
module distribute_multimode
  import distribute_pkg::*;
#(
  parameter int GROUP_SIZE             = 4,
  parameter int DATA_WIDTH             = 8,
  parameter int NUM_INPUTS             = 4,
  parameter int NUM_LANES              = 4,
  parameter int LOG_MAX_ITERS          = 8,
  parameter int LOG_MAX_READS_PER_ITER = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          configure,
  input  logic [1:0]                                    conf_mode,
  input  logic [LOG_MAX_ITERS-1:0]                      num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]             num_reads_per_iter,
  input  logic [NUM_INPUTS*GROUP_SIZE*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS-1:0]                         in_valid,
  output logic [NUM_INPUTS-1:0]                         in_avail,
  output logic [NUM_LANES*GROUP_SIZE*DATA_WIDTH-1:0]    out_data,
  output logic [NUM_LANES-1:0]                          out_valid,
  input  logic [NUM_LANES-1:0]                          out_avail,
  output logic                                          busy,
  output logic                                          done
);

  localparam int GW   = GROUP_SIZE * DATA_WIDTH;
  localparam int NACT = (NUM_INPUTS < NUM_LANES) ? NUM_INPUTS : NUM_LANES;
  localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE = 1;
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE = 1;

  state_t r_state, w_stateNext;
  mode_t  r_mode, w_confMode;
  logic [LOG_MAX_ITERS-1:0]                             r_numIters;
  logic [LOG_MAX_READS_PER_ITER-1:0]                    r_numReads;
  logic [NUM_INPUTS-1:0][LOG_MAX_READS_PER_ITER-1:0]    r_readCnt;
  logic [NUM_INPUTS-1:0][LOG_MAX_ITERS-1:0]             r_iterCnt;
  logic [NUM_INPUTS-1:0]                                r_exhausted;
  logic [NUM_INPUTS-1:0]                                w_active, w_inAvail, w_accept;
  logic [NUM_LANES-1:0]                                 w_space, w_load, w_laneValid;
  logic [NUM_LANES-1:0][GW-1:0]                         w_laneIn, w_laneOut;
  logic w_start, w_zeroCount, w_allExhausted;

`ifdef DISTRIBUTE_RR_MODE_EN
  localparam int RR_W = (NUM_LANES > 1) ? clog2(NUM_LANES) : 1;
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_LANES - 1);
  localparam logic [RR_W-1:0] RR_ONE  = 1;
  logic [RR_W-1:0] r_rrPtr;
`endif

  assign w_start     = (r_state == ST_IDLE) && configure;
  assign w_zeroCount = (num_iters == '0) || (num_reads_per_iter == '0);

  // Reserved mode, and round-robin when it is compiled out, collapse to direct at latch time.
  always_comb begin
    w_confMode = MODE_DIRECT;
    case (conf_mode)
      2'd1:    w_confMode = MODE_BCAST;
`ifdef DISTRIBUTE_RR_MODE_EN
      2'd2:    w_confMode = MODE_RR;
`endif
      default: w_confMode = MODE_DIRECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_DIRECT;
      r_numIters <= '0;
      r_numReads <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_start) begin
        r_mode     <= w_confMode;
        r_numIters <= num_iters;
        r_numReads <= num_reads_per_iter;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (configure) w_stateNext = w_zeroCount ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_allExhausted) w_stateNext = ST_DRAIN;
      ST_DRAIN: if (w_laneValid == '0) w_stateNext = ST_DONE;
      ST_DONE:  w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active = '0;
    if (r_mode == MODE_DIRECT) begin
      for (int i = 0; i < NACT; i++) w_active[i] = 1'b1;
    end else begin
      w_active[0] = 1'b1;
    end
  end

  // Streams that take no part in the current mode count as already exhausted.
  assign w_allExhausted = &(r_exhausted | ~w_active);

  // Routing: which streams may be offered, and which lanes load which word.
  always_comb begin
    w_inAvail = '0;
    w_load    = '0;
    for (int l = 0; l < NUM_LANES; l++) w_laneIn[l] = in_data[0 +: GW];
    if (r_mode == MODE_DIRECT) begin
      for (int l = 0; l < NACT; l++) w_laneIn[l] = in_data[l*GW +: GW];
    end
    if (r_state == ST_RUN) begin
      case (r_mode)
        MODE_BCAST: w_inAvail[0] = (&w_space) & ~r_exhausted[0];
`ifdef DISTRIBUTE_RR_MODE_EN
        MODE_RR:    w_inAvail[0] = w_space[r_rrPtr] & ~r_exhausted[0];
`endif
        default: begin
          for (int i = 0; i < NACT; i++) w_inAvail[i] = w_space[i] & ~r_exhausted[i];
        end
      endcase
    end
    w_accept = in_valid & w_inAvail;
    case (r_mode)
      MODE_BCAST: w_load = {NUM_LANES{w_accept[0]}};
`ifdef DISTRIBUTE_RR_MODE_EN
      MODE_RR:    w_load[r_rrPtr] = w_accept[0];
`endif
      default: begin
        for (int l = 0; l < NACT; l++) w_load[l] = w_accept[l];
      end
    endcase
  end

  // Nested read/iteration counters, one set per stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_readCnt   <= '0;
      r_iterCnt   <= '0;
      r_exhausted <= '0;
    end else if (w_start) begin
      r_readCnt   <= '0;
      r_iterCnt   <= '0;
      r_exhausted <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_accept[i]) begin
          if (r_readCnt[i] == r_numReads - READ_ONE) begin
            r_readCnt[i] <= '0;
            if (r_iterCnt[i] == r_numIters - ITER_ONE) begin
              r_exhausted[i] <= 1'b1;
            end else begin
              r_iterCnt[i] <= r_iterCnt[i] + ITER_ONE;
            end
          end else begin
            r_readCnt[i] <= r_readCnt[i] + READ_ONE;
          end
        end
      end
    end
  end

`ifdef DISTRIBUTE_RR_MODE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr <= '0;
    end else if (w_start) begin
      r_rrPtr <= '0;
    end else if ((r_mode == MODE_RR) && w_accept[0]) begin
      r_rrPtr <= (r_rrPtr == RR_LAST) ? '0 : r_rrPtr + RR_ONE;
    end
  end
`endif

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    distribute_lane_reg #(.GW(GW)) u_laneReg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[l]),
      .i_data  (w_laneIn[l]),
      .i_avail (out_avail[l]),
      .o_space (w_space[l]),
      .o_data  (w_laneOut[l]),
      .o_valid (w_laneValid[l])
    );
    assign out_data[l*GW +: GW] = w_laneOut[l];
  end

  assign out_valid = w_laneValid;
  assign in_avail  = w_inAvail;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_distribute_multimode.sv
// Scoreboard bench for distribute_multimode: expected lane words are queued at configure
// time from the mode rules, and a negedge monitor pops them on every lane handshake.
module tb_distribute_multimode;

  localparam int GS   = 4;
  localparam int DW   = 8;
  localparam int NI   = 4;
  localparam int NL   = 4;
  localparam int GW   = GS * DW;
  localparam int NACT = (NI < NL) ? NI : NL;

  localparam int DATA_RAND = 0;
  localparam int DATA_A0   = 1;
  localparam int DATA_IDX  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             configure;
  logic [1:0]       conf_mode;
  logic [7:0]       num_iters;
  logic [7:0]       num_reads_per_iter;
  logic [NI*GW-1:0] in_data;
  logic [NI-1:0]    in_valid;
  logic [NI-1:0]    in_avail;
  logic [NL*GW-1:0] out_data;
  logic [NL-1:0]    out_valid;
  logic [NL-1:0]    out_avail;
  logic             busy;
  logic             done;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;

  logic [GW-1:0] words [NI][$];
  logic [GW-1:0] expQ  [NL][$];
  int            idx   [NI];

  distribute_multimode #(
    .GROUP_SIZE(GS), .DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_LANES(NL),
    .LOG_MAX_ITERS(8), .LOG_MAX_READS_PER_ITER(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .conf_mode          (conf_mode),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_avail           (in_avail),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_avail          (out_avail),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every lane handshake must match the head of that lane's expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (done) doneCount++;
      for (int l = 0; l < NL; l++) begin
        if (out_valid[l] && out_avail[l]) begin
          if (expQ[l].size() == 0) begin
            checkOutput($sformatf("unexpected_word_lane%0d", l), out_data[l*GW +: GW], 128'hx);
          end else begin
            checkOutput($sformatf("lane%0d_data", l), out_data[l*GW +: GW], expQ[l].pop_front());
          end
        end
      end
    end
  end

  function automatic int effectiveMode(input int mode);
`ifdef DISTRIBUTE_RR_MODE_EN
    if (mode == 2) return 2;
`endif
    if (mode == 1) return 1;
    return 0;
  endfunction

  function automatic bit isActive(input int eff, input int i);
    if (eff == 0) return (i < NACT);
    return (i == 0);
  endfunction

  // Runs one configuration; abortAfter > 0 stops driving after that many run cycles.
  task automatic applyStimulus(input int mode, input int iters, input int reads, input int dataKind,
                               input bit randHs, input bit stallLane2, input int abortAfter);
    int eff, n, cyc, waitCyc;
    bit allFed;
    logic [NI-1:0] allowed;
    logic [NL-1:0] expValid;
    logic [7:0] b;
    eff = effectiveMode(mode);
    n   = iters * reads;
    doneCount = 0;
    for (int i = 0; i < NI; i++) begin
      words[i].delete();
      idx[i] = 0;
      for (int k = 0; k < n; k++) begin
        b = 8'hA0 + 8'(k);
        if (dataKind == DATA_A0)       words[i].push_back({GS{b}});
        else if (dataKind == DATA_IDX) words[i].push_back(GW'(k));
        else                           words[i].push_back($urandom());
      end
    end
    for (int k = 0; k < n; k++) begin
      if (eff == 1) begin
        for (int l = 0; l < NL; l++) expQ[l].push_back(words[0][k]);
      end else if (eff == 2) begin
        expQ[k % NL].push_back(words[0][k]);
      end else begin
        for (int l = 0; l < NACT; l++) expQ[l].push_back(words[l][k]);
      end
    end

    @(posedge clk); #1;
    configure          = 1'b1;
    conf_mode          = 2'(mode);
    num_iters          = 8'(iters);
    num_reads_per_iter = 8'(reads);
    in_valid           = '0;
    out_avail          = '1;

    cyc = 0;
    allFed = 1'b0;
    while (!allFed && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      configure = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (isActive(eff, i) && idx[i] < n) begin
          in_data[i*GW +: GW] = words[i][idx[i]];
          in_valid[i] = randHs ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          in_data[i*GW +: GW] = $urandom();
          in_valid[i] = $urandom_range(0, 1) == 1;
        end
      end
      for (int l = 0; l < NL; l++) out_avail[l] = randHs ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stallLane2 && cyc >= 3 && cyc <= 5) out_avail[2] = 1'b0;

      @(negedge clk);
      allowed = '0;
      for (int i = 0; i < NI; i++) allowed[i] = isActive(eff, i) && (idx[i] < n);
      checkOutput("in_avail_gate", in_avail & ~allowed, '0);
      if (stallLane2 && cyc >= 3 && cyc <= 5) checkOutput("bcast_stall_avail", in_avail[0], 1'b0);
      if (eff == 0 && !randHs && cyc == 2) begin
        expValid = '0;
        for (int l = 0; l < NACT; l++) expValid[l] = 1'b1;
        checkOutput("direct_latency_valid", out_valid, expValid);
      end
      for (int i = 0; i < NI; i++) begin
        if (in_valid[i] && in_avail[i] && allowed[i]) idx[i]++;
      end
      allFed = 1'b1;
      for (int i = 0; i < NI; i++) if (isActive(eff, i) && idx[i] < n) allFed = 1'b0;
      if (abortAfter > 0 && cyc >= abortAfter) return;
    end
    checkOutput("all_words_accepted", allFed, 1'b1);

    @(posedge clk); #1;
    in_valid  = '0;
    out_avail = '1;
    waitCyc = 0;
    while (doneCount == 0 && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("done_seen", doneCount > 0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("done_once", doneCount, 1);
    checkOutput("busy_after_done", busy, 1'b0);
    for (int l = 0; l < NL; l++) checkOutput($sformatf("scoreboard_empty_lane%0d", l), expQ[l].size(), 0);
  endtask

  task automatic zeroCountRun(input int iters, input int reads);
    doneCount = 0;
    @(posedge clk); #1;
    configure          = 1'b1;
    conf_mode          = 2'd0;
    num_iters          = 8'(iters);
    num_reads_per_iter = 8'(reads);
    in_valid           = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("zero_busy", busy, 1'b0);
      checkOutput("zero_in_avail", in_avail, '0);
      @(posedge clk); #1;
      configure = 1'b0;
    end
    in_valid = '0;
    checkOutput("zero_done_once", doneCount, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, out_valid, '0);
    checkOutput({tag, "_out_data"},  out_data,  '0);
    checkOutput({tag, "_in_avail"},  in_avail,  '0);
    checkOutput({tag, "_busy"},      busy,      1'b0);
    checkOutput({tag, "_done"},      done,      1'b0);
  endtask

  initial begin
    rst                = 1'b0;
    configure          = 1'b0;
    conf_mode          = 2'd0;
    num_iters          = '0;
    num_reads_per_iter = '0;
    in_data            = '0;
    in_valid           = '0;
    out_avail          = '1;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b1;

    $display("[TB] direct mode, full throughput");
    applyStimulus(0, 2, 4, DATA_RAND, 1'b0, 1'b0, 0);
    $display("[TB] broadcast with lane 2 stall");
    applyStimulus(1, 2, 4, DATA_A0, 1'b0, 1'b1, 0);
    $display("[TB] mode 2 with index data");
    applyStimulus(2, 1, 8, DATA_IDX, 1'b0, 1'b0, 0);
    applyStimulus(2, 2, 5, DATA_RAND, 1'b1, 1'b0, 0);
    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 4), DATA_RAND, 1'b1, 1'b0, 0);
    end
    $display("[TB] zero-length runs");
    zeroCountRun(0, 4);
    zeroCountRun(3, 0);

    $display("[TB] reset mid-run");
    applyStimulus(0, 2, 4, DATA_RAND, 1'b0, 1'b0, 3);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("midrun_reset");
    for (int l = 0; l < NL; l++) expQ[l].delete();
    in_valid = '0;
    @(posedge clk); #3;
    rst = 1'b1;
    applyStimulus(0, 2, 4, DATA_RAND, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
